// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a synchronous FIFO. A requester can keep
// the port for up to MAX_BURST consecutive words before priority rotates.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       push,
  output logic [WIDTH-1:0]           data_i,
  input  logic                       full,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [7:0]                 burst_cnt
);

  localparam int OW = $clog2(NUM_REQ);

  logic [OW-1:0] r_owner;
  logic [7:0]    r_burst_cnt;

  logic [OW-1:0] w_idx;
  logic [OW-1:0] w_rot_idx;
  logic [OW-1:0] w_win;
  logic          w_cont;
  logic          w_push;

  // Scan from owner+NUM_REQ down to owner+1 so the nearest requester after
  // the owner is the last match to land; the owner itself comes last.
  always_comb begin
    w_idx     = '0;
    w_rot_idx = r_owner;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = OW'((int'(r_owner) + k) % NUM_REQ);
      if (req[w_idx]) w_rot_idx = w_idx;
    end
  end

  assign w_cont = req[r_owner] && (r_burst_cnt != 8'd0) &&
                  (r_burst_cnt < 8'(MAX_BURST));
  assign w_win  = w_cont ? r_owner : w_rot_idx;
  assign w_push = ~rst & ~full & (|req);

  always_comb begin
    gnt    = '0;
    data_i = '0;
    if (w_push) begin
      gnt[w_win] = 1'b1;
      data_i     = req_data[int'(w_win)*WIDTH +: WIDTH];
    end
  end

  assign push = w_push;

  // A stall on full with the owner still requesting leaves the burst open.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OW'(NUM_REQ - 1);
      r_burst_cnt <= 8'd0;
    end else if (w_push) begin
      if (w_cont) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end else begin
        r_owner     <= w_win;
        r_burst_cnt <= 8'd1;
      end
    end else if (!req[r_owner]) begin
      r_burst_cnt <= 8'd0;
    end
  end

  assign owner     = r_owner;
  assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios on a MAX_BURST=2 and a
// MAX_BURST=1 instance, then random traffic against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req, gnt;
  logic [N*W-1:0] req_data;
  logic           push, full;
  logic [W-1:0]   data_i;
  logic [1:0]     owner;
  logic [7:0]     burst_cnt;

  logic [N-1:0]   req1, gnt1;
  logic [N*W-1:0] req_data1;
  logic           push1, full1;
  logic [W-1:0]   data1;
  logic [1:0]     owner1;
  logic [7:0]     bc1;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .push(push), .data_i(data_i), .full(full), .owner(owner),
    .burst_cnt(burst_cnt));

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_data(req_data1), .gnt(gnt1),
    .push(push1), .data_i(data1), .full(full1), .owner(owner1),
    .burst_cnt(bc1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_rst(input string tag, input logic [3:0] r);
    @(negedge clk);
    rst = 1'b1; req = r; req1 = r; full = 1'b0; full1 = 1'b0;
    #1;
    chk({tag, ".gnt"},   gnt,   4'h0);
    chk({tag, ".push"},  push,  1'b0);
    chk({tag, ".gnt1"},  gnt1,  4'h0);
    chk({tag, ".push1"}, push1, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".owner"},  owner,     2'd3);
    chk({tag, ".bc"},     burst_cnt, 8'd0);
    chk({tag, ".owner1"}, owner1,    2'd3);
    chk({tag, ".bc1"},    bc1,       8'd0);
    rst = 1'b0; req = '0; req1 = '0;
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic f,
                      input logic [3:0] eg, input logic [7:0] ed,
                      input logic [1:0] eo, input logic [7:0] eb);
    @(negedge clk);
    req = r; full = f;
    #1;
    chk({tag, ".gnt"},  gnt,    eg);
    chk({tag, ".push"}, push,   |eg);
    chk({tag, ".data"}, data_i, ed);
    @(posedge clk); #1;
    chk({tag, ".owner"}, owner,     eo);
    chk({tag, ".bc"},    burst_cnt, eb);
  endtask

  logic [N-1:0] preq;
  logic [W-1:0] pdata [N];
  int           waitc [N];
  int           m_owner, m_bc, cnt, ew;
  logic         ev, econt, found;
  logic [N-1:0] eg;

  initial begin
    rst = 1'b0; req = '0; req1 = '0; full = 1'b0; full1 = 1'b0;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_data1 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // all requesting, bursts of two
    do_rst("rst0", 4'hF);
    step("rr0", 4'hF, 1'b0, 4'b0001, 8'hA0, 2'd0, 8'd1);
    step("rr1", 4'hF, 1'b0, 4'b0001, 8'hA0, 2'd0, 8'd2);
    step("rr2", 4'hF, 1'b0, 4'b0010, 8'hB1, 2'd1, 8'd1);
    step("rr3", 4'hF, 1'b0, 4'b0010, 8'hB1, 2'd1, 8'd2);
    step("rr4", 4'hF, 1'b0, 4'b0100, 8'hC2, 2'd2, 8'd1);
    step("rr5", 4'hF, 1'b0, 4'b0100, 8'hC2, 2'd2, 8'd2);
    step("rr6", 4'hF, 1'b0, 4'b1000, 8'hD3, 2'd3, 8'd1);
    step("rr7", 4'hF, 1'b0, 4'b1000, 8'hD3, 2'd3, 8'd2);

    // pure round-robin instance alternates 0,2,0,2
    do_rst("rst1", 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req1 = 4'b0101;
      #1;
      chk("mb1.gnt",  gnt1,  (i % 2 == 0) ? 4'b0001 : 4'b0100);
      chk("mb1.data", data1, (i % 2 == 0) ? 8'hA0 : 8'hC2);
      @(posedge clk); #1;
      chk("mb1.owner", owner1, (i % 2 == 0) ? 2'd0 : 2'd2);
      chk("mb1.bc",    bc1,    8'd1);
    end
    req1 = '0;

    // burst held open across a full stall
    do_rst("rst2", 4'h0);
    step("fs0", 4'b0010, 1'b0, 4'b0010, 8'hB1, 2'd1, 8'd1);
    step("fs1", 4'b0010, 1'b1, 4'b0000, 8'h00, 2'd1, 8'd1);
    step("fs2", 4'b0010, 1'b1, 4'b0000, 8'h00, 2'd1, 8'd1);
    step("fs3", 4'b0010, 1'b1, 4'b0000, 8'h00, 2'd1, 8'd1);
    step("fs4", 4'b0010, 1'b0, 4'b0010, 8'hB1, 2'd1, 8'd2);
    step("fs5", 4'b0010, 1'b0, 4'b0010, 8'hB1, 2'd1, 8'd1);
    step("fs6", 4'b0011, 1'b0, 4'b0010, 8'hB1, 2'd1, 8'd2);
    step("fs7", 4'b0011, 1'b0, 4'b0001, 8'hA0, 2'd0, 8'd1);

    // owner drops mid-burst, then idle closes the burst
    do_rst("rst3", 4'h0);
    step("dr0", 4'b0100, 1'b0, 4'b0100, 8'hC2, 2'd2, 8'd1);
    step("dr1", 4'b1000, 1'b0, 4'b1000, 8'hD3, 2'd3, 8'd1);
    step("dr2", 4'b0000, 1'b0, 4'b0000, 8'h00, 2'd3, 8'd0);

    // reset in the middle of a burst
    step("mr0", 4'b0100, 1'b0, 4'b0100, 8'hC2, 2'd2, 8'd1);
    do_rst("rst4", 4'hF);
    step("mr1", 4'hF, 1'b0, 4'b0001, 8'hA0, 2'd0, 8'd1);

    // random traffic against the reference model
    do_rst("rst5", 4'h0);
    m_owner = N - 1; m_bc = 0; cnt = 0; preq = '0;
    for (int i = 0; i < N; i++) begin pdata[i] = '0; waitc[i] = 0; end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (preq[i]) begin
          if ($urandom_range(0, 15) == 0) begin preq[i] = 1'b0; waitc[i] = 0; end
        end else if ($urandom_range(0, 3) == 0) begin
          preq[i] = 1'b1; pdata[i] = W'($urandom);
        end
      end
      full = (cnt == DEPTH);
      req  = preq;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = pdata[i];
      #1;

      ev = 1'b0; econt = 1'b0; ew = 0; found = 1'b0;
      if (!full && preq != '0) begin
        ev = 1'b1;
        if (preq[m_owner] && m_bc > 0 && m_bc < MB) begin
          ew = m_owner; econt = 1'b1;
        end else begin
          for (int k = 1; k <= N; k++) begin
            if (!found && preq[(m_owner + k) % N]) begin
              ew = (m_owner + k) % N; found = 1'b1;
            end
          end
        end
      end
      eg = '0;
      if (ev) eg[ew] = 1'b1;

      chk("rnd.gnt",    gnt,    eg);
      chk("rnd.push",   push,   ev);
      chk("rnd.data",   data_i, ev ? pdata[ew] : 8'h00);
      chk("rnd.onehot", ($countones(gnt) <= 1), 1'b1);
      if (ev) chk("rnd.wait", (waitc[ew] <= (N - 1) * MB), 1'b1);

      @(posedge clk); #1;
      if (ev) begin
        if (econt) m_bc++;
        else begin m_owner = ew; m_bc = 1; end
        for (int i = 0; i < N; i++) begin
          if (i == ew) waitc[i] = 0;
          else if (preq[i]) waitc[i]++;
        end
        preq[ew] = 1'b0;
        cnt++;
      end else if (!preq[m_owner]) begin
        m_bc = 0;
      end
      if (cnt > 0 && $urandom_range(0, 2) != 0) cnt--;

      chk("rnd.owner", owner,     m_owner);
      chk("rnd.bc",    burst_cnt, m_bc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port (push/data_i/full) of the synchronous FIFO between NUM_REQ independent producers.
- Arbitration is round-robin with an optional bounded burst, so one producer can stream up to MAX_BURST words back-to-back before priority rotates.
- Sits directly in front of the FIFO push side; the FIFO's pop side is untouched.

Parameters:
- WIDTH, 8, data word width; matches the FIFO WIDTH.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- MAX_BURST, 2, maximum consecutive grants to one owner before rotation; 1 gives pure round-robin; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester write request; bit i is requester i.
- req_data  input  NUM_REQ*WIDTH  per-requester data; slice [i*WIDTH +: WIDTH] belongs to requester i.
- gnt  output  NUM_REQ  one-hot (or zero) grant; the word from that requester is written this cycle.
- push  output  1  FIFO write strobe; equals |gnt.
- data_i  output  WIDTH  FIFO write data; the granted requester's slice.
- full  input  1  FIFO full flag.
- owner  output  $clog2(NUM_REQ)  registered index of the most recent grant winner.
- burst_cnt  output  8  registered count of grants in the current burst.

Behaviour:
- Grant path is combinational in the current cycle.
  - If full=1, gnt=0 and push=0.
  - Otherwise at most one gnt bit is set, and only for a requester with req=1.
- When push=0, data_i is driven to 0.
- Handshake: a requester holds req and its data stable until it sees gnt. gnt=1 means the word is consumed at this posedge. The requester may keep req high for the next word.
- Requests may be withdrawn at any time without a grant; no word is written.
- Winner selection when full=0:
  - Continue: the current owner wins if req[owner]=1 and burst_cnt<MAX_BURST and burst_cnt!=0.
  - Rotate: otherwise the first requester with req=1 in circular order owner+1, owner+2, ..., owner wins. The owner itself is therefore the last priority.
- State update at posedge:
  - New winner (different from owner, or rotation back to the same owner): owner<=winner, burst_cnt<=1.
  - Continuation: burst_cnt<=burst_cnt+1.
  - No grant and req[owner]=0: burst_cnt<=0 (burst closed).
  - No grant because full=1 while req[owner]=1: owner and burst_cnt hold, so the burst resumes when full drops.
- MAX_BURST=1 never continues; every grant rotates.
- Reset (rst=1 at posedge): owner<=NUM_REQ-1 so requester 0 has top priority first; burst_cnt<=0.
- During the reset cycle gnt=0 and push=0 regardless of req/full. Reset mid-burst discards the burst with no write.
- The arbiter never writes a full FIFO. Throughput is one word per cycle while full=0 and any req=1.
- Wrap: the search index wraps modulo NUM_REQ, including non-power-of-two NUM_REQ; out-of-range indices are never granted.

Test Plan:
- Reset, then req=4'b1111 with full=0 for 8 cycles (NUM_REQ=4, MAX_BURST=2) -> gnt sequence 0,0,1,1,2,2,3,3; push=1 every cycle; data_i matches the granted slice each cycle.
- req=4'b0101 continuous with MAX_BURST=1 -> gnt alternates 0,2,0,2; owner follows; burst_cnt stays 1.
- Requester 1 alone, full rises after its first grant for 3 cycles then drops -> grants: 1 word, 0 for 3 cycles, then 1 word with burst_cnt=2, then gnt rotates if any other req is present, else burst_cnt=1 (new burst).
- Owner 2 drops req mid-burst (burst_cnt=1) while req[3]=1 -> next grant is 3, owner=3, burst_cnt=1; in a later idle cycle with req[owner]=0, burst_cnt=0.
- Assert rst in the middle of the sequence above -> gnt=0 and push=0 in the reset cycle; afterwards owner=3, burst_cnt=0; next grant with req=4'b1111 is 0.
- Random req/full for 10k cycles against a scoreboard FIFO model -> no push while full, at most one gnt bit set, no requester waits more than (NUM_REQ-1)*MAX_BURST non-full grant cycles, data order matches per-requester order.
